key_tone_player: RTL

Parametrised successor to the keypad → frequency ROM → PWM tone path. It debounces the keypad scanner's pressed flag and produces a one-cycle write strobe for the color register bank in place of a level write. It generates a square-wave tone from a half-period table, and can record up to FIFO_DEPTH key presses and play them back with fixed note and gap lengths. It sits between the keypad scanner and the board audio pin, and drives the color RAM write port.

---
 rtl/key_tone_player_pkg.sv | 25 ++
 rtl/key_tone_player_debounce.sv | 65 ++++++
 rtl/key_tone_player.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/key_tone_player_pkg.sv
// Shared types for key_tone_player: FSM states, mode encodings, key event pulses.
package key_tone_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LIVE      = 2'd1,
    ST_PLAY_NOTE = 2'd2,
    ST_PLAY_GAP  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LIVE = 2'b00;
  localparam logic [1:0] MODE_REC  = 2'b01;
  localparam logic [1:0] MODE_PLAY = 2'b10;

  // Single-cycle pulses on debounced press/release edges.
  typedef struct packed {
    logic rise;
    logic fall;
  } key_evt_t;

  function automatic logic is_tone(state_t s);
    return (s == ST_LIVE) || (s == ST_PLAY_NOTE);
  endfunction

endpackage

// File: rtl/key_tone_player_debounce.sv
// key_debounce: 2-FF synchronizer plus optional stability filter on key_opr.
// KEY_TONE_DEBOUNCE_EN selects the DEB_CYCLES filter; otherwise the synchronized level is used.
module key_debounce
  import key_tone_player_pkg::*;
`ifdef KEY_TONE_DEBOUNCE_EN
#(
  parameter int DEB_CYCLES = 50000
)
`endif
(
  input  logic     clk,
  input  logic     rst,
  input  logic     key_opr,
  output key_evt_t evt
);

  logic [1:0] sync_pipe;
  logic       key_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_pipe <= '0;
    else      sync_pipe <= {sync_pipe[0], key_opr};
  end

  assign key_s = sync_pipe[1];

`ifdef KEY_TONE_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             pressed;

  // pressed flips only after key_s has disagreed with it for DEB_CYCLES straight cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      pressed <= 1'b0;
      evt     <= '0;
    end else begin
      evt <= '0;
      if (key_s == pressed) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        cnt_q    <= '0;
        pressed  <= key_s;
        evt.rise <= key_s;
        evt.fall <= ~key_s;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
`else
  logic key_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) key_d <= 1'b0;
    else      key_d <= key_s;
  end

  assign evt.rise = key_s & ~key_d;
  assign evt.fall = ~key_s & key_d;
`endif

endmodule

// File: rtl/key_tone_player.sv
// key_tone_player: keypad press strobe, square-wave tone, record/playback of key presses.
// Build option: define KEY_TONE_DEBOUNCE_EN to enable the DEB_CYCLES debounce filter.
module key_tone_player
  import key_tone_player_pkg::*;
#(
  parameter  int KEYS        = 16,
  parameter  int DIV_W       = 16,
  parameter  int DEB_CYCLES  = 50000,
  parameter  int NOTE_CYCLES = 12500000,
  parameter  int GAP_CYCLES  = 2500000,
  parameter  int FIFO_DEPTH  = 8,
  localparam int ADDR_W      = $clog2(KEYS),
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] key_pos,
  input  logic              key_opr,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] div_addr,
  input  logic [DIV_W-1:0]  div_data,
  output logic              tone_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_full
);

  localparam int IDX_W  = CNT_W - 1;
  localparam int PH_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  if (DEB_CYCLES < 1 || NOTE_CYCLES < 1 || GAP_CYCLES < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
    $error("key_tone_player: invalid parameter set");
  end

  key_evt_t evt;

  key_debounce
`ifdef KEY_TONE_DEBOUNCE_EN
    #(.DEB_CYCLES(DEB_CYCLES))
`endif
    u_deb (
      .clk     (clk),
      .rst     (rst),
      .key_opr (key_opr),
      .evt     (evt)
    );

  state_t                           state_q, state_d;
  logic [1:0]                       mode_q;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] fifo_q;
  logic [CNT_W-1:0]                 fifo_count_q, fifo_base;
  logic [IDX_W-1:0]                 rd_idx_q;
  logic [PH_W-1:0]                  ph_cnt_q;
  logic [DIV_W-1:0]                 tone_cnt_q;
  logic                             tone_q, play_done_q, wr_en_q;
  logic [ADDR_W-1:0]                wr_addr_q;
  logic                             press_ok, push, rec_entry, last_entry, tone_run;

  // Presses arriving while mode selects playback are dropped entirely.
  assign press_ok   = evt.rise && (mode != MODE_PLAY);
  assign rec_entry  = (mode == MODE_REC) && (mode_q != MODE_REC);
  assign push       = wr_en_q && (mode == MODE_REC);
  assign fifo_base  = rec_entry ? '0 : fifo_count_q;
  assign last_entry = (CNT_W'(rd_idx_q) + CNT_W'(1)) == fifo_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_LIVE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      mode_q  <= mode;
      wr_en_q <= press_ok;
      if (press_ok) wr_addr_q <= key_pos;
    end
  end

  // Record-mode entry empties the FIFO before any same-cycle push lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q       <= '0;
      fifo_count_q <= '0;
    end else if (push && fifo_base < CNT_W'(FIFO_DEPTH)) begin
      fifo_q[fifo_base[IDX_W-1:0]] <= wr_addr_q;
      fifo_count_q                 <= fifo_base + CNT_W'(1);
    end else begin
      fifo_count_q <= fifo_base;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mode == MODE_PLAY) begin
          if (fifo_count_q != '0 && !play_done_q) state_d = ST_PLAY_NOTE;
        end else if (evt.rise) begin
          state_d = ST_LIVE;
        end
      end
      ST_LIVE: if (evt.fall) state_d = ST_IDLE;
      ST_PLAY_NOTE: begin
        if (mode != MODE_PLAY)                         state_d = evt.rise ? ST_LIVE : ST_IDLE;
        else if (ph_cnt_q == PH_W'(NOTE_CYCLES - 1))   state_d = ST_PLAY_GAP;
      end
      ST_PLAY_GAP: begin
        if (mode != MODE_PLAY)                         state_d = evt.rise ? ST_LIVE : ST_IDLE;
        else if (ph_cnt_q == PH_W'(GAP_CYCLES - 1))    state_d = last_entry ? ST_IDLE : ST_PLAY_NOTE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    div_addr = '0;
    unique case (state_q)
      ST_LIVE:      div_addr = wr_addr_q;
      ST_PLAY_NOTE: begin busy = 1'b1; div_addr = fifo_q[rd_idx_q]; end
      ST_PLAY_GAP:  busy = 1'b1;
      default:      ;
    endcase
  end

  // play_done holds off an automatic replay until mode leaves playback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_cnt_q    <= '0;
      rd_idx_q    <= '0;
      play_done_q <= 1'b0;
    end else begin
      ph_cnt_q <= (state_d != state_q || !busy) ? '0 : ph_cnt_q + PH_W'(1);
      if (state_q == ST_IDLE)
        rd_idx_q <= '0;
      else if (state_q == ST_PLAY_GAP && state_d == ST_PLAY_NOTE)
        rd_idx_q <= rd_idx_q + IDX_W'(1);
      if (mode != MODE_PLAY)
        play_done_q <= 1'b0;
      else if (state_q == ST_PLAY_GAP && state_d == ST_IDLE)
        play_done_q <= 1'b1;
    end
  end

  // Tone runs only while staying in a tone state, so every entry restarts it from zero.
  assign tone_run = is_tone(state_q) && (state_d == state_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (!tone_run || div_data == '0) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (tone_cnt_q == div_data - DIV_W'(1)) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + DIV_W'(1);
    end
  end

  assign tone_out   = tone_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign fifo_count = fifo_count_q;
  assign fifo_full  = (fifo_count_q == CNT_W'(FIFO_DEPTH));

endmodule
